fifo_cola_umbral: RTL and testbench
===================================

// Module: fifo_cola_umbral
// PURPOSE
//  Synchronous single-clock FIFO with programmable almost-full/almost-empty thresholds.
//  Instantiated 4x upstream of arbitro1: feeds fifo_data_in*, fifos_empty; consumes fifos_pop.
//  Instantiated 4x downstream: fed by fifos_push/fifo_data_out*, returns fifos_almost_full.
//  Provides back-pressure so the arbiter never writes into a full queue.
// PARAMETERS
//  WORD_SIZE        12  data word width in bits
//  ADDR_SIZE        3   pointer width; DEPTH = 2**ADDR_SIZE = 8 entries
//  ALMOST_FULL_LVL  6   almost_full asserted when count >= this value (1..DEPTH)
//  ALMOST_EMPTY_LVL 1   almost_empty asserted when count <= this value (0..DEPTH-1)
// PORTS
//  clk          in   1             rising-edge clock
//  reset        in   1             asynchronous, active-high reset
//  push         in   1             write data_in this cycle
//  pop          in   1             read head word this cycle
//  data_in      in   WORD_SIZE     write data
//  data_out     out  WORD_SIZE     registered read data
//  valid_out    out  1             data_out updated by a successful pop on the last edge
//  full         out  1             count == DEPTH
//  empty        out  1             count == 0
//  almost_full  out  1             count >= ALMOST_FULL_LVL
//  almost_empty out  1             count <= ALMOST_EMPTY_LVL
//  error        out  1             overflow/underflow indication
//  count        out  ADDR_SIZE+1   current occupancy 0..DEPTH
// BEHAVIOUR
//  Reset (async, immediate): wr_ptr=rd_ptr=0, count=0, data_out=0, valid_out=0,
//   error=0, empty=1, almost_empty=1, full=0, almost_full=0. Memory contents not cleared.
//  Storage: DEPTH x WORD_SIZE register array; wr_ptr/rd_ptr ADDR_SIZE bits, wrap DEPTH-1 -> 0.
//  Push accepted iff push && (!full || pop): mem[wr_ptr]<=data_in, wr_ptr++.
//  Pop accepted iff pop && !empty: data_out<=mem[rd_ptr], rd_ptr++, valid_out<=1 next cycle.
//  Read latency: 1 cycle; word popped at edge N is on data_out after edge N.
//  No accepted pop: data_out holds last value, valid_out<=0.
//  count: +1 push only, -1 pop only, unchanged on both or neither accepted.
//  Flags decoded combinationally from count register; update in cycle after the edge.
//  Full + push + pop: both accepted, count stays DEPTH, no error.
//  Empty + push + pop: push accepted, pop rejected (no bypass), underflow error.
//  Full + push, no pop: write dropped, pointers unchanged, overflow error.
//  Empty + pop: no state change, data_out holds, underflow error.
//  error: registered; set on the edge where overflow or underflow occurs.
//  Reset mid-operation: all state cleared at once; no partial write completes.
// CONFIGURATION
//  FIFO_ERR_STICKY_EN defined: error stays 1 after first overflow/underflow until reset.
//  FIFO_ERR_STICKY_EN undefined: error is a one-cycle pulse for each offending edge;
//   next clean edge clears it to 0.
// TESTING
//  Reset: reset=1 mid-run, count=5 -> count=0, empty=1, almost_empty=1, data_out=0 immediately.
//  Fill: 8 pushes 12'hA01..12'hA08 -> almost_full high after 6th edge, full after 8th, error=0.
//  Overflow: 9th push 12'hFFF when full -> count stays 8, error=1; later pops never return 12'hFFF.
//  Drain order: 8 pops -> data_out 12'hA01..12'hA08 one edge after each pop, valid_out=1 each;
//   empty=1 after last.
//  Underflow: pop when empty -> error=1, data_out holds 12'hA08, valid_out=0;
//   sticky build keeps error=1, pulse build clears next edge.
//  Wrap/simultaneous: count=8 after pointer wrap, push 12'h5A5 + pop together -> count=8,
//   data_out=oldest word, 12'h5A5 popped last after 7 more pops.

Source files
------------

// File: rtl/fifo_cola_umbral.sv
// fifo_cola_umbral: single-clock FIFO with programmable almost-full/almost-empty thresholds.
// Define FIFO_ERR_STICKY_EN to hold error high from the first overflow/underflow until reset.
module fifo_cola_umbral #(
  parameter int WORD_SIZE        = 12,
  parameter int ADDR_SIZE        = 3,
  parameter int ALMOST_FULL_LVL  = 6,
  parameter int ALMOST_EMPTY_LVL = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error,
  output logic [ADDR_SIZE:0]   count
);
  localparam int DEPTH = 2 ** ADDR_SIZE;
  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop, err_evt;
  assign full         = count == (ADDR_SIZE+1)'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= (ADDR_SIZE+1)'(ALMOST_FULL_LVL);
  assign almost_empty = count <= (ADDR_SIZE+1)'(ALMOST_EMPTY_LVL);
  // a pop frees the slot, so a full queue still accepts a simultaneous push
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign err_evt = (push && full && !pop) || (pop && empty);
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      wr_ptr    <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr    <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count     <= (do_push && !do_pop) ? count + 1'b1 : (do_pop && !do_push) ? count - 1'b1 : count;
      data_out  <= do_pop ? mem[rd_ptr] : data_out;
      valid_out <= do_pop;
`ifdef FIFO_ERR_STICKY_EN
      error     <= error | err_evt;
`else
      error     <= err_evt;
`endif
    end
endmodule

// File: tb/tb_fifo_cola_umbral.sv
// tb_fifo_cola_umbral: directed and randomized checks of fifo_cola_umbral against a queue model.
module tb_fifo_cola_umbral;
  logic        clk = 0, reset = 1, push = 0, pop = 0;
  logic [11:0] data_in = 0, data_out;
  logic        valid_out, full, empty, almost_full, almost_empty, error;
  logic [3:0]  count;
  int checks = 0, errors = 0;
  logic [11:0] mq[$];
  logic [11:0] m_dout = 0;
  logic        m_valid = 0, m_err = 0;

  fifo_cola_umbral dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic p, input logic q, input logic [11:0] d);
    bit m_full, m_empty, evt;
    push = p; pop = q; data_in = d;
    @(posedge clk);
    m_full  = mq.size() == 8;
    m_empty = mq.size() == 0;
    evt     = (p && m_full && !q) || (q && m_empty);
    m_valid = q && !m_empty;
    if (m_valid) m_dout = mq.pop_front();
    if (p && (!m_full || q)) mq.push_back(d);
`ifdef FIFO_ERR_STICKY_EN
    m_err = m_err | evt;
`else
    m_err = evt;
`endif
    #1;
    push = 0; pop = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic pulse_reset();
    #2 reset = 1;
    #2 reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({count, data_out, valid_out, error, empty, almost_empty, full, almost_full} !== {4'd0, 12'd0, 6'b001100}) begin
      errors++;
      $display("FAIL reset_initial got cnt=%0d dout=%h v=%b e=%b em=%b ae=%b f=%b af=%b exp cnt=0 dout=000 v=0 e=0 em=1 ae=1 f=0 af=0",
               count, data_out, valid_out, error, empty, almost_empty, full, almost_full);
    end
    @(negedge clk) reset = 0;
    model_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 12'h300 + 12'(i));
    step(0, 1, 0);
    checks++;
    if (count !== 4'd5 || data_out !== 12'h300) begin
      errors++;
      $display("FAIL reset_prefill got cnt=%0d dout=%h exp cnt=5 dout=300", count, data_out);
    end
    #2 reset = 1;
    #1;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || data_out !== 12'h000) begin
      errors++;
      $display("FAIL reset_midrun got cnt=%0d em=%b ae=%b dout=%h exp cnt=0 em=1 ae=1 dout=000", count, empty, almost_empty, data_out);
    end
    #2 reset = 0;
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 12'hA01 + 12'(i));
      checks++;
      if (count !== 4'(i + 1) || almost_full !== (i >= 5) || full !== (i == 7) || error !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d got cnt=%0d af=%b f=%b e=%b exp cnt=%0d af=%b f=%b e=0",
                 i, count, almost_full, full, error, i + 1, i >= 5, i == 7);
      end
    end
  endtask

  task automatic test_overflow();
    step(1, 0, 12'hFFF);
    checks++;
    if (count !== 4'd8 || error !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow got cnt=%0d e=%b f=%b exp cnt=8 e=1 f=1", count, error, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      checks++;
      if (data_out !== 12'hA01 + 12'(i) || valid_out !== 1'b1 || error !== m_err) begin
        errors++;
        $display("FAIL drain_%0d got dout=%h v=%b e=%b exp dout=%h v=1 e=%b", i, data_out, valid_out, error, 12'hA01 + 12'(i), m_err);
      end
    end
    checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL drain_empty got em=%b cnt=%0d exp em=1 cnt=0", empty, count);
    end
  endtask

  task automatic test_underflow();
    step(0, 1, 0);
    checks++;
    if (error !== 1'b1 || data_out !== 12'hA08 || valid_out !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL underflow got e=%b dout=%h v=%b cnt=%0d exp e=1 dout=a08 v=0 cnt=0", error, data_out, valid_out, count);
    end
    step(0, 0, 0);
    checks++;
    if (error !== m_err) begin
      errors++;
      $display("FAIL underflow_after got e=%b exp e=%b", error, m_err);
    end
  endtask

  task automatic test_wrap_simultaneous();
    pulse_reset();
    step(1, 1, 12'h111);
    checks++;
    if (count !== 4'd1 || error !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL empty_push_pop got cnt=%0d e=%b v=%b exp cnt=1 e=1 v=0", count, error, valid_out);
    end
    step(0, 1, 0);
    checks++;
    if (data_out !== 12'h111 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL nobypass_pop got dout=%h v=%b exp dout=111 v=1", data_out, valid_out);
    end
    for (int i = 0; i < 8; i++) step(1, 0, 12'hB00 + 12'(i));
    checks++;
    if (count !== 4'd8 || full !== 1'b1) begin
      errors++;
      $display("FAIL wrap_full got cnt=%0d f=%b exp cnt=8 f=1", count, full);
    end
    step(1, 1, 12'h5A5);
    checks++;
    if (count !== 4'd8 || data_out !== 12'hB00 || error !== m_err || m_err !== error) begin
      errors++;
      $display("FAIL full_push_pop got cnt=%0d dout=%h e=%b exp cnt=8 dout=b00 e=%b", count, data_out, error, m_err);
    end
    for (int i = 1; i < 8; i++) begin
      step(0, 1, 0);
      checks++;
      if (data_out !== 12'hB00 + 12'(i)) begin
        errors++;
        $display("FAIL wrap_pop_%0d got dout=%h exp dout=%h", i, data_out, 12'hB00 + 12'(i));
      end
    end
    step(0, 1, 0);
    checks++;
    if (data_out !== 12'h5A5 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_last got dout=%h em=%b exp dout=5a5 em=1", data_out, empty);
    end
  endtask

  task automatic test_random();
    int sz;
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 99) < (n < 200 ? 65 : 35)), 1'($urandom_range(0, 99) < 50), 12'($urandom));
      sz = mq.size();
      checks++;
      if ({count, data_out, valid_out, error, full, empty, almost_full, almost_empty} !==
          {4'(sz), m_dout, m_valid, m_err, sz == 8, sz == 0, sz >= 6, sz <= 1}) begin
        errors++;
        $display("FAIL random_%0d got cnt=%0d dout=%h v=%b e=%b f=%b em=%b af=%b ae=%b exp cnt=%0d dout=%h v=%b e=%b",
                 n, count, data_out, valid_out, error, full, empty, almost_full, almost_empty, sz, m_dout, m_valid, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_wrap_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
